snn_input_current_accum: RTL and testbench
==========================================

Name: snn_input_current_accum

Overview:
- Parametrised, time-multiplexed synaptic current accumulator for the SNN neuron datapath.
- On a start handshake, latches M spike bits and M signed weights. Sums the weights of active spikes over M/LANES beats, saturates the sum to a signed OW-bit current, and signals completion with a one-cycle valid pulse.
- Sits between the spike/weight fabric and the LIF neuron update. Trades latency for adder area when M is large.

Parameters:
- M, 8, number of input spikes/weights; must be a multiple of LANES.
- W, 8, signed weight width (two's complement).
- OW, 8, signed output current width; OW <= ACCW.
- LANES, 2, weights summed per beat; 1 <= LANES <= M.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new accumulation; accepted only when busy=0.
- input_spikes  in  M  spike vector; sampled on the accepted start.
- weights  in  M*W  flattened signed weights, weight i at [i*W +: W]; sampled on the accepted start.
- busy  out  1  high while an accumulation is in flight.
- current_valid  out  1  one-cycle pulse when input_current is updated.
- input_current  out  OW  saturated signed current; held until the next update.

Behaviour:
- Derived constants (localparam):
  - BEATS = M/LANES.
  - ACCW = W + clog2(M) + 1. Always wide enough: no internal overflow is possible.
- FSM states:
  - IDLE: busy=0. start=1 latches spikes and weights into local registers, clears acc, clears beat counter, and moves to ACCUM.
  - ACCUM: busy=1. Each cycle adds the sign-extended weights whose latched spike bit is 1 for lanes beat*LANES .. beat*LANES+LANES-1, then increments beat. After beat BEATS-1, moves to SAT.
  - SAT: busy=1. Loads the clamped acc into input_current, pulses current_valid for one cycle, returns to IDLE.
- Clamp rule:
  - acc > 2^(OW-1)-1 gives 2^(OW-1)-1.
  - acc < -2^(OW-1) gives -2^(OW-1).
  - Otherwise acc[OW-1:0].
- Latency:
  - Start accepted at edge 0.
  - Beats occur at edges 1..BEATS.
  - input_current and current_valid update at edge BEATS+1. Fixed latency; zero-spike beats are still consumed.
- Throughput: one result per BEATS+2 cycles. start may be asserted in the same cycle current_valid is high; it is accepted because state is IDLE on that edge.
- start while busy=1: ignored, no queueing. Changes to input_spikes/weights after acceptance have no effect.
- All-zero spikes: result 0, valid still pulses.
- Reset, including mid-operation:
  - State returns to IDLE.
  - busy=0, current_valid=0, input_current=0.
  - acc, beat and latched registers are cleared.
  - No valid is issued for the aborted job.
- LANES=M: BEATS=1, latency 2 cycles.

Optional Feature:
- Macro: SNN_CURRENT_BIAS_EN.
- Defined:
  - Adds input port bias, W bits, signed. It is latched with the accepted start.
  - Bias is added into acc on the IDLE->ACCUM transition (acc initialised to sign-extended bias instead of 0).
  - ACCW grows by 1.
  - Clamp and latency are unchanged.
- Undefined: no bias port; acc initialises to 0.

Decomposition:
- Shared package snn_pkg:
  - clog2 function.
  - FSM state typedef/encoding (IDLE=2'd0, ACCUM=2'd1, SAT=2'd2).
  - Saturating-clamp function parameterised by the in/out widths, reused by the neuron update.
- One natural sub-module, snn_lane_adder: combinational sum of LANES masked, sign-extended weights. The top owns the FSM, counter and registers.

Test Plan (defaults M=8, W=8, OW=8, LANES=2; latency 5):
- Spikes=8'h0F, weights w0..w3=10,20,-5,7, rest 99; start at cycle 0 -> current_valid at edge 5 only, input_current=32; busy high edges 1..5.
- Spikes=8'hFF, all weights=100 -> input_current=127. All weights=-100 -> input_current=-128 (8'h80).
- Spikes=8'h00 -> input_current=0; valid pulses at edge 5.
- start held high continuously with the case-1 vector -> one result every 6 cycles. Changing weights mid-job does not alter the result; extra starts during busy are ignored.
- reset asserted at edge 3 of a job -> outputs 0 immediately, no valid. A new start after reset yields the correct result with full latency.
- SNN_CURRENT_BIAS_EN defined, bias=-40, spikes=8'h0F as in case 1 -> input_current=-8. With bias=127 and spikes=8'hFF, weights=100 -> saturates to 127.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared SNN datapath package: FSM encoding, clog2 and a saturating clamp
// that the current accumulator and the neuron update both use.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_e;

  // Widest intermediate the clamp handles; callers sign-extend into it.
  localparam int SAT_MAX_W = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Clamp a signed value to the range of a signed ow-bit number; the caller
  // truncates the result to ow bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
    input logic signed [SAT_MAX_W-1:0] val,
    input int                          ow
  );
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (ow - 1));
    if (val > max_v) return max_v;
    if (val < min_v) return min_v;
    return val;
  endfunction

endpackage

// File: rtl/snn_lane_adder.sv
// Combinational sum of LANES sign-extended weights, each gated by its spike bit.
module snn_lane_adder #(
  parameter int LANES = 2,
  parameter int W     = 8,
  parameter int ACCW  = 12
) (
  input  logic [LANES-1:0]         lane_spikes_i,
  input  logic [LANES*W-1:0]       lane_weights_i,
  output logic signed [ACCW-1:0]   lane_sum_o
);

  logic signed [W-1:0] w_i;

  // NOTE: combinational accumulation uses blocking '=' so each loop step sees
  // the previous partial sum; every output gets a default first so no latch forms.
  always_comb begin
    lane_sum_o = '0;
    w_i        = '0;
    for (int i = 0; i < LANES; i++) begin
      w_i = lane_weights_i[i*W +: W];
      if (lane_spikes_i[i]) lane_sum_o = lane_sum_o + ACCW'(w_i);
    end
  end

endmodule

// File: rtl/snn_input_current_accum.sv
// Time-multiplexed synaptic current accumulator: LANES weights per beat, result
// saturated to OW bits. Define SNN_CURRENT_BIAS_EN to add a latched signed bias input.
module snn_input_current_accum
  import snn_pkg::*;
#(
  parameter int M     = 8,
  parameter int W     = 8,
  parameter int OW    = 8,
  parameter int LANES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [M-1:0]      input_spikes,
  input  logic [M*W-1:0]    weights,
`ifdef SNN_CURRENT_BIAS_EN
  input  logic [W-1:0]      bias,
`endif
  output logic              busy,
  output logic              current_valid,
  output logic [OW-1:0]     input_current
);

  localparam int BEATS = M / LANES;
`ifdef SNN_CURRENT_BIAS_EN
  localparam int ACCW  = W + clog2(M) + 2;
`else
  localparam int ACCW  = W + clog2(M) + 1;
`endif
  localparam int BW    = (BEATS > 1) ? clog2(BEATS) : 1;

  state_e                  state_q;
  logic [M-1:0]            spikes_q;
  logic [M*W-1:0]          weights_q;
  logic signed [ACCW-1:0]  acc_q;
  logic [BW-1:0]           beat_q;
  logic [OW-1:0]           current_q;
  logic                    valid_q;
`ifdef SNN_CURRENT_BIAS_EN
  logic [W-1:0]            bias_q;
`endif

  logic [31:0]             lane_base;
  logic [31:0]             bit_base;
  logic [LANES-1:0]        lane_spikes;
  logic [LANES*W-1:0]      lane_weights;
  logic signed [ACCW-1:0]  lane_sum;
  logic signed [ACCW-1:0]  acc_d;
  logic signed [ACCW-1:0]  acc_init_d;
  logic [OW-1:0]           current_d;

  // Shifting the latched vectors down selects the current beat's lanes
  // without a variable-width part-select.
  always_comb begin
    lane_base    = 32'(beat_q) * 32'(LANES);
    bit_base     = 32'(beat_q) * 32'(LANES * W);
    lane_spikes  = LANES'(spikes_q >> lane_base);
    lane_weights = (LANES*W)'(weights_q >> bit_base);
    acc_d        = acc_q + lane_sum;
    current_d    = OW'(sat_clamp(64'(acc_q), OW));
`ifdef SNN_CURRENT_BIAS_EN
    acc_init_d   = ACCW'($signed(bias));
`else
    acc_init_d   = '0;
`endif
  end

  snn_lane_adder #(
    .LANES (LANES),
    .W     (W),
    .ACCW  (ACCW)
  ) u_lane_adder (
    .lane_spikes_i  (lane_spikes),
    .lane_weights_i (lane_weights),
    .lane_sum_o     (lane_sum)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values. The latched operand registers are reset too, so an
  // aborted job leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      spikes_q  <= '0;
      weights_q <= '0;
      acc_q     <= '0;
      beat_q    <= '0;
      current_q <= '0;
      valid_q   <= 1'b0;
`ifdef SNN_CURRENT_BIAS_EN
      bias_q    <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            spikes_q  <= input_spikes;
            weights_q <= weights;
            acc_q     <= acc_init_d;
            beat_q    <= '0;
            state_q   <= ACCUM;
`ifdef SNN_CURRENT_BIAS_EN
            bias_q    <= bias;
`endif
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (beat_q == BW'(BEATS - 1)) begin
            state_q <= SAT;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        SAT: begin
          current_q <= current_d;
          valid_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign current_valid = valid_q;
  assign input_current = current_q;

endmodule

// File: tb/tb_snn_input_current_accum.sv
// Directed bench for snn_input_current_accum (M=8, W=8, OW=8, LANES=2): expected
// currents are queued at each start and compared when current_valid pulses.
module tb_snn_input_current_accum;

  localparam int M = 8;
  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [M-1:0]   spikes;
  logic [M*W-1:0] weights;
  logic [W-1:0]   bias;
  logic           busy;
  logic           current_valid;
  logic [7:0]     input_current;

  int             total;
  int             bad;
  int             valid_cnt;
  logic [7:0]     exp_q[$];

  snn_input_current_accum #(
    .M     (M),
    .W     (W),
    .OW    (8),
    .LANES (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .input_spikes  (spikes),
    .weights       (weights),
`ifdef SNN_CURRENT_BIAS_EN
    .bias          (bias),
`endif
    .busy          (busy),
    .current_valid (current_valid),
    .input_current (input_current)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fill(input logic [7:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] sp, input logic [63:0] wt,
                                       input logic [7:0] b);
    int s;
    logic signed [7:0] wi;
    logic signed [7:0] bi;
    bi = b;
    s  = int'(bi);
    for (int i = 0; i < 8; i++) begin
      wi = wt[i*8 +: 8];
      if (sp[i]) s += int'(wi);
    end
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s[7:0];
  endfunction

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && current_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("unexpected_valid", current_valid, 0);
      else check("current", input_current, exp_q.pop_front());
    end
  end

  // Starts one job from an idle cycle and checks busy/valid timing edge by edge.
  // With glitch set, a second start with different data arrives mid-job.
  task automatic run_job(input string tag, input logic [7:0] sp, input logic [63:0] wt,
                         input logic [7:0] b, input bit glitch);
    start   = 1'b1;
    spikes  = sp;
    weights = wt;
    bias    = b;
    exp_q.push_back(model(sp, wt, b));
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy0"}, busy, 1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (glitch && k == 1) begin
        start   = 1'b1;
        spikes  = 8'hFF;
        weights = fill(8'd100);
      end
      if (glitch && k == 2) start = 1'b0;
      check({tag, "_valid"}, current_valid, (k == 5));
      check({tag, "_busy"}, busy, (k < 5));
    end
  endtask

  logic [63:0] w1;
  int          vc0;

  initial begin
    total     = 0;
    bad       = 0;
    valid_cnt = 0;
    reset     = 1'b1;
    start     = 1'b0;
    spikes    = '0;
    weights   = '0;
    bias      = '0;
    w1 = fill(8'd99);
    w1[7:0]   = 8'd10;
    w1[15:8]  = 8'd20;
    w1[23:16] = 8'hFB;
    w1[31:24] = 8'd7;

    repeat (2) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_valid", current_valid, 0);
    check("rst_current", input_current, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_job("case1", 8'h0F, w1, 8'd0, 1'b0);
    run_job("pos_sat", 8'hFF, fill(8'd100), 8'd0, 1'b0);
    run_job("neg_sat", 8'hFF, fill(8'h9C), 8'd0, 1'b0);
    run_job("zero", 8'h00, fill(8'd55), 8'd0, 1'b0);
    run_job("busy_start", 8'h0F, w1, 8'd0, 1'b1);

    // start held high: accepted at edges 0, 6, 12 with results at 5, 11, 17.
    start   = 1'b1;
    spikes  = 8'h0F;
    weights = w1;
    bias    = 8'd0;
    repeat (3) exp_q.push_back(model(8'h0F, w1, 8'd0));
    vc0 = valid_cnt;
    for (int e = 0; e <= 17; e++) begin
      @(posedge clk); #1;
      if (e == 2) weights = '0;
      if (e == 4) weights = w1;
      check("held_valid", current_valid, (e == 5 || e == 11 || e == 17));
    end
    start = 1'b0;
    check("held_count", valid_cnt - vc0, 3);

    // Reset three edges into a job: outputs clear at once, no valid follows.
    @(posedge clk); #1;
    start   = 1'b1;
    spikes  = 8'hFF;
    weights = fill(8'd100);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", current_valid, 0);
    check("abort_current", input_current, 0);
    vc0 = valid_cnt;
    repeat (4) @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("abort_no_valid", valid_cnt - vc0, 0);
    run_job("after_rst", 8'hFF, fill(8'h9C), 8'd0, 1'b0);

`ifdef SNN_CURRENT_BIAS_EN
    run_job("bias_neg", 8'h0F, w1, 8'hD8, 1'b0);
    run_job("bias_sat", 8'hFF, fill(8'd100), 8'd127, 1'b0);
`endif

    repeat (3) @(posedge clk); #1;
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
